// File: rtl/retry_issue_ctrl.sv
// Issues one latched request on the link and re-issues it on nack/timeout up to MAX_RETRY times.
// Optional feature macro: RETRY_BACKOFF_EN (inserts a BACKOFF_CYC-cycle idle gap before each re-issue).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | ready for a new request, timeout counter held clear
// S_SEND    | tx_valid asserted with the latched payload until tx_ready
// S_WAIT    | timeout counter running, waiting for ack / nack / cnt_flag
// S_BACKOFF | (RETRY_BACKOFF_EN only) idle gap before the next re-issue
module retry_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int MAX_RETRY   = 3,
    parameter int BACKOFF_CYC = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [DATA_W-1:0]              req_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [DATA_W-1:0]              tx_data,
    input  logic                           ack,
    input  logic                           nack,
    output logic                           cnt_clean,
    output logic                           cnt_en,
    input  logic                           cnt_flag,
    output logic                           done,
    output logic                           fail,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int RCW = $clog2(MAX_RETRY + 1);

    generate
        if (MAX_RETRY < 1) begin : g_bad_max_retry
            $error("MAX_RETRY must be at least 1");
        end
        if (BACKOFF_CYC < 1) begin : g_bad_backoff
            $error("BACKOFF_CYC must be at least 1");
        end
    endgenerate

`ifdef RETRY_BACKOFF_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_BACKOFF} state_t;
    localparam int BW = $clog2(BACKOFF_CYC + 1);
    logic [BW-1:0] bo_q, bo_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;
`endif

    state_t             state_q, state_d;
    logic [RCW-1:0]     retry_q, retry_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic               retry_left;

    assign retry_left = (retry_q < RCW'(MAX_RETRY));

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        data_d  = data_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
`ifdef RETRY_BACKOFF_EN
        bo_d    = bo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    data_d  = req_data;
                    retry_d = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                // ack wins over nack, nack over timeout
                if (ack) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (nack || cnt_flag) begin
                    if (retry_left) begin
                        retry_d = retry_q + 1'b1;
`ifdef RETRY_BACKOFF_EN
                        bo_d    = BW'(BACKOFF_CYC - 1);
                        state_d = S_BACKOFF;
`else
                        state_d = S_SEND;
`endif
                    end else begin
                        fail_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef RETRY_BACKOFF_EN
            S_BACKOFF: begin
                if (bo_q == '0) state_d = S_SEND;
                else            bo_d    = bo_q - 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            retry_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
`ifdef RETRY_BACKOFF_EN
            bo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
`ifdef RETRY_BACKOFF_EN
            bo_q    <= bo_d;
`endif
        end
    end

    // Reset overrides the state decode so the link and counter are quiet immediately
    assign req_ready = rst_n && (state_q == S_IDLE);
    assign tx_valid  = rst_n && (state_q == S_SEND);
    assign cnt_en    = rst_n && (state_q == S_WAIT);
    assign cnt_clean = !rst_n || (state_q == S_IDLE) || ((state_q == S_SEND) && tx_ready);
    assign tx_data   = data_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_retry_issue_ctrl.sv
// Scoreboard bench for retry_issue_ctrl with a saturating timeout counter model (MAX_NUM=8).
// Build with RETRY_BACKOFF_EN defined to exercise the backoff gap.
module tb_retry_issue_ctrl;

    localparam int DW = 32;
    localparam int MAX_NUM = 8;
    localparam int EV_TX = 0, EV_DONE = 1, EV_FAIL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_data = '0;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [DW-1:0] tx_data;
    logic          ack = 1'b0;
    logic          nack = 1'b0;
    logic          cnt_clean;
    logic          cnt_en;
    logic          cnt_flag;
    logic          done;
    logic          fail;
    logic [1:0]    retry_cnt;

    logic [3:0]    tcnt = '0;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          retry;
    } ev_t;
    ev_t sbq[$];

    int n_cmp = 0;
    int n_err = 0;

    retry_issue_ctrl #(.DATA_W(DW), .MAX_RETRY(3), .BACKOFF_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .ack(ack), .nack(nack),
        .cnt_clean(cnt_clean), .cnt_en(cnt_en), .cnt_flag(cnt_flag),
        .done(done), .fail(fail), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // External timeout counter: clear wins, saturates at MAX_NUM
    always @(posedge clk) begin
        if (cnt_clean) tcnt <= '0;
        else if (cnt_en && tcnt != 4'(MAX_NUM)) tcnt <= tcnt + 4'd1;
    end
    assign cnt_flag = (tcnt == 4'(MAX_NUM));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int k, input logic [31:0] d, input int r);
        ev_t e;
        e.kind = k; e.data = d; e.retry = r;
        sbq.push_back(e);
    endtask

    task automatic check_ev(input int k, input logic [31:0] d, input int r);
        ev_t e;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d data %h retry %0d, expected none", k, d, r);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || (k == EV_TX && e.data !== d) || (k != EV_TX && e.retry != r)) begin
                n_err++;
                $display("FAIL event: got kind %0d data %h retry %0d, expected kind %0d data %h retry %0d",
                         k, d, r, e.kind, e.data, e.retry);
            end
        end
    endtask

    // Monitor: every handshake and every done/fail pulse must match the scoreboard head
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) check_ev(EV_TX, tx_data, 0);
        if (done === 1'b1) check_ev(EV_DONE, '0, int'(retry_cnt));
        if (fail === 1'b1) check_ev(EV_FAIL, '0, int'(retry_cnt));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs();
        int k = 0;
        while (!(tx_valid && tx_ready) && k < 40) begin
            cyc();
            k++;
        end
        if (k == 40) begin
            n_cmp++; n_err++;
            $display("FAIL hs_timeout: got no handshake in 40 cycles, expected one");
        end else begin
            cyc();
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!req_ready && k < 40) begin
            cyc();
            k++;
        end
        if (k == 40) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: got req_ready=0 for 40 cycles, expected 1");
        end
    endtask

    task automatic respond(input int code);
        int k = 0;
        case (code)
            0: begin repeat (3) cyc(); ack = 1'b1;  cyc(); ack = 1'b0;  end
            1: begin repeat (2) cyc(); nack = 1'b1; cyc(); nack = 1'b0; end
            3: begin
                while (!cnt_flag && k < 40) begin cyc(); k++; end
                if (k == 40) begin
                    n_cmp++; n_err++;
                    $display("FAIL flag_timeout: got cnt_flag=0, expected 1");
                end
                ack = 1'b1; cyc(); ack = 1'b0;
            end
            default: ;
        endcase
    endtask

    // codes: 0 ack after delay, 1 nack after delay, 2 silence (timeout), 3 ack on the flag cycle
    task automatic run_req(input logic [31:0] d, input int n, input int c0, input int c1,
                           input int c2, input int c3, input int exp_kind, input int exp_retry);
        int codes[4];
        codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
        for (int i = 0; i < n; i++) push_ev(EV_TX, d, 0);
        push_ev(exp_kind, '0, exp_retry);
        req_data = d; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wait_hs();
            respond(codes[i]);
        end
        wait_idle();
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        // Test 1: reset and single acked request
        cyc();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_cnt_en", 32'(cnt_en), 32'd0);
        chk("rst_cnt_clean", 32'(cnt_clean), 32'd1);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_retry", 32'(retry_cnt), 32'd0);
        chk("post_rst_tx_data", tx_data, 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        cyc();

        push_ev(EV_TX, 32'hA5A50001, 0);
        push_ev(EV_DONE, '0, 0);
        req_data = 32'hA5A50001; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("t1_tx_valid_latency", 32'(tx_valid), 32'd1);
        chk("t1_tx_data", tx_data, 32'hA5A50001);
        cyc();
        respond(0);
        chk("t1_done_pulse", 32'(done), 32'd1);
        chk("t1_retry", 32'(retry_cnt), 32'd0);
        cyc();
        chk("t1_done_single", 32'(done), 32'd0);
        chk("t1_req_ready", 32'(req_ready), 32'd1);

        // Test 2: nack, nack, ack
        run_req(32'h12345678, 3, 1, 1, 0, 0, EV_DONE, 2);
        // Test 3: four timeouts, retries exhausted
        run_req(32'hDEADBEEF, 4, 2, 2, 2, 2, EV_FAIL, 3);
        // Test 4: ack coincides with cnt_flag on the final attempt
        run_req(32'h0BADF00D, 4, 2, 2, 2, 3, EV_DONE, 3);

        // Test 5: tx_ready stalled in SEND
        push_ev(EV_TX, 32'hCAFE0005, 0);
        push_ev(EV_DONE, '0, 0);
        tx_ready = 1'b0;
        req_data = 32'hCAFE0005; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        req_data = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("t5_tx_valid", 32'(tx_valid), 32'd1);
            chk("t5_tx_data", tx_data, 32'hCAFE0005);
            chk("t5_cnt_en", 32'(cnt_en), 32'd0);
            chk("t5_cnt_clean", 32'(cnt_clean), 32'd0);
            cyc();
        end
        tx_ready = 1'b1;
        #1;
        chk("t5_clean_on_hs", 32'(cnt_clean), 32'd1);
        cyc();
        chk("t5_cnt_en_wait", 32'(cnt_en), 32'd1);
        respond(0);
        wait_idle();
        cyc();

        // Test 6: reset in WAIT after one retry
        push_ev(EV_TX, 32'h66660006, 0);
        push_ev(EV_TX, 32'h66660006, 0);
        req_data = 32'h66660006; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        wait_hs();
        respond(1);
        wait_hs();
        chk("t6_retry_before_rst", 32'(retry_cnt), 32'd1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_clean_in_rst", 32'(cnt_clean), 32'd1);
        chk("t6_en_in_rst", 32'(cnt_en), 32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t6_req_ready", 32'(req_ready), 32'd1);
        chk("t6_tx_valid", 32'(tx_valid), 32'd0);
        chk("t6_retry", 32'(retry_cnt), 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("t6_no_done", 32'(done), 32'd0);
            chk("t6_no_fail", 32'(fail), 32'd0);
            cyc();
        end

        // Test 7: gap between nack and re-issue
        push_ev(EV_TX, 32'h77770007, 0);
        push_ev(EV_TX, 32'h77770007, 0);
        push_ev(EV_DONE, '0, 1);
        req_data = 32'h77770007; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        wait_hs();
        respond(1);
        gap = 0;
        while (!tx_valid && gap < 20) begin
            gap++;
            cyc();
        end
`ifdef RETRY_BACKOFF_EN
        chk("t7_backoff_gap", 32'(gap), 32'd4);
`else
        chk("t7_retry_gap", 32'(gap), 32'd0);
`endif
        wait_hs();
        respond(0);
        wait_idle();
        repeat (3) cyc();

        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending events, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
